// File: rtl/debayer_line_sched_if.sv
// Control bundle between the CSI aligner / de-Bayer datapath and the line scheduler.
// The master drives frame/line framing and error clear; the slave returns buffer control.
interface debayer_line_sched_if #(
  parameter int unsigned LINE_LENGTH = 640,
  parameter int unsigned CNT_W       = $clog2(LINE_LENGTH + 1)
);
  logic             frame_start;
  logic             frame_end;
  logic             data_valid;
  logic             err_clr;
  logic             wr_en;
  logic [1:0]       wr_sel;
  logic [CNT_W-1:0] wr_addr;
  logic             rd_en;
  logic [CNT_W-1:0] rd_addr;
  logic             rd_odd;
  logic [1:0]       rd_skip_sel;
  logic             rgb_valid;
  logic [15:0]      lines_out;
  logic             err_len;
  logic             err_overrun;

  modport master (
    output frame_start, frame_end, data_valid, err_clr,
    input  wr_en, wr_sel, wr_addr, rd_en, rd_addr, rd_odd, rd_skip_sel,
    input  rgb_valid, lines_out, err_len, err_overrun
  );

  modport slave (
    input  frame_start, frame_end, data_valid, err_clr,
    output wr_en, wr_sel, wr_addr, rd_en, rd_addr, rd_odd, rd_skip_sel,
    output rgb_valid, lines_out, err_len, err_overrun
  );
endinterface

// File: rtl/debayer_line_sched.sv
// Write-slot rotation, read-triple scheduling and address sequencing for the 4-line
// de-Bayer line buffer, with line-length and overrun detection.
module debayer_line_sched #(
  parameter int unsigned LINE_LENGTH = 640,
  parameter int unsigned CNT_W       = $clog2(LINE_LENGTH + 1),
  parameter int unsigned LAT         = 2
) (
  input logic                  clk,
  input logic                  rst,
  debayer_line_sched_if.slave  io_bus
);

  localparam logic [CNT_W-1:0] LastAddr = CNT_W'(LINE_LENGTH - 1);
  localparam logic [CNT_W-1:0] FullAddr = CNT_W'(LINE_LENGTH);

  typedef enum logic {FIdle, FActive} fstate_e;
  typedef enum logic [1:0] {RIdle, RLine, RGap} rstate_e;

  fstate_e          r_fstate;
  rstate_e          r_rstate;
  logic             r_dv_prev;
  logic             r_in_line;
  logic [1:0]       r_lines_written;
  logic             r_pending;
  logic [1:0]       r_skip_next;
  logic             r_wr_en;
  logic [1:0]       r_wr_sel;
  logic [CNT_W-1:0] r_wr_addr;
  logic             r_rd_en;
  logic [CNT_W-1:0] r_rd_addr;
  logic             r_rd_odd;
  logic [1:0]       r_rd_skip_sel;
  logic [LAT-1:0]   r_rgb_pipe;
  logic [15:0]      r_lines_out;
  logic             r_err_len;
  logic             r_err_overrun;

  logic       w_active;
  logic       w_rise;
  logic       w_fall;
  logic [1:0] w_lw_inc;
  logic [1:0] w_wr_sel_inc;

  assign w_active     = (r_fstate == FActive);
  assign w_rise       = w_active && io_bus.data_valid && !r_dv_prev;
  // Only lines that actually started inside the frame can complete.
  assign w_fall       = w_active && !io_bus.data_valid && r_dv_prev && r_in_line;
  assign w_lw_inc     = (r_lines_written == 2'd3) ? 2'd3 : r_lines_written + 2'd1;
  assign w_wr_sel_inc = r_wr_sel + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fstate        <= FIdle;
      r_rstate        <= RIdle;
      r_dv_prev       <= 1'b0;
      r_in_line       <= 1'b0;
      r_lines_written <= 2'd0;
      r_pending       <= 1'b0;
      r_skip_next     <= 2'd3;
      r_wr_en         <= 1'b0;
      r_wr_sel        <= 2'd0;
      r_wr_addr       <= '0;
      r_rd_en         <= 1'b0;
      r_rd_addr       <= '0;
      r_rd_odd        <= 1'b0;
      r_rd_skip_sel   <= 2'd3;
      r_lines_out     <= 16'd0;
      r_err_len       <= 1'b0;
      r_err_overrun   <= 1'b0;
    end else begin
      r_dv_prev <= io_bus.data_valid;

      if (io_bus.frame_start) begin
        r_fstate <= FActive;
      end else if (io_bus.frame_end) begin
        r_fstate <= FIdle;
      end

      // Clear first so that a same-cycle error set below takes precedence.
      if (io_bus.err_clr) begin
        r_err_len     <= 1'b0;
        r_err_overrun <= 1'b0;
      end

      r_wr_en <= 1'b0;
      if (io_bus.frame_start) begin
        r_in_line       <= 1'b0;
        r_wr_sel        <= 2'd0;
        r_lines_written <= 2'd0;
      end else if (w_rise) begin
        r_in_line <= 1'b1;
        r_wr_en   <= 1'b1;
        r_wr_addr <= '0;
        if (r_rstate == RLine && r_wr_sel != r_rd_skip_sel) begin
          r_err_overrun <= 1'b1;
        end
      end else if (w_fall) begin
        r_in_line       <= 1'b0;
        r_wr_sel        <= w_wr_sel_inc;
        r_lines_written <= w_lw_inc;
      end else if (w_active && io_bus.data_valid && r_in_line) begin
        if (r_wr_addr < LastAddr) begin
          r_wr_addr <= r_wr_addr + 1'b1;
          r_wr_en   <= 1'b1;
        end else begin
          r_wr_addr <= FullAddr;
          r_err_len <= 1'b1;
        end
      end

      // A new completion overrides consumption so only the newest triple is kept.
      if (io_bus.frame_start) begin
        r_pending <= 1'b0;
      end else if (w_fall && w_lw_inc == 2'd3) begin
        r_pending   <= 1'b1;
        r_skip_next <= w_wr_sel_inc;
      end else if (r_rstate == RIdle && r_pending) begin
        r_pending <= 1'b0;
      end

      if (io_bus.frame_start) begin
        r_rstate    <= RIdle;
        r_rd_en     <= 1'b0;
        r_lines_out <= 16'd0;
      end else begin
        unique case (r_rstate)
          RIdle: begin
            if (r_pending) begin
              r_rd_skip_sel <= r_skip_next;
              r_rd_addr     <= '0;
              r_rd_odd      <= 1'b0;
              r_rd_en       <= 1'b1;
              r_rstate      <= RLine;
            end
          end
          RLine: begin
            r_rd_odd <= ~r_rd_odd;
            if (r_rd_odd) begin
              if (r_rd_addr == LastAddr) begin
                r_rstate    <= RGap;
                r_rd_en     <= 1'b0;
                r_lines_out <= r_lines_out + 16'd1;
              end else begin
                r_rd_addr <= r_rd_addr + 1'b1;
              end
            end
          end
          RGap:    r_rstate <= RIdle;
          default: r_rstate <= RIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb_pipe <= '0;
    end else begin
      r_rgb_pipe[0] <= r_rd_en;
      for (int i = 1; i < int'(LAT); i++) begin
        r_rgb_pipe[i] <= r_rgb_pipe[i-1];
      end
    end
  end

  assign io_bus.wr_en       = r_wr_en;
  assign io_bus.wr_sel      = r_wr_sel;
  assign io_bus.wr_addr     = r_wr_addr;
  assign io_bus.rd_en       = r_rd_en;
  assign io_bus.rd_addr     = r_rd_addr;
  assign io_bus.rd_odd      = r_rd_odd;
  assign io_bus.rd_skip_sel = r_rd_skip_sel;
  assign io_bus.rgb_valid   = r_rgb_pipe[LAT-1];
  assign io_bus.lines_out   = r_lines_out;
  assign io_bus.err_len     = r_err_len;
  assign io_bus.err_overrun = r_err_overrun;

endmodule

// File: tb/tb_debayer_line_sched.sv
// Directed bench for debayer_line_sched: frame/line scenarios with hand-computed expectations
// checked by immediate assertions; a negedge monitor tallies strobes and read sequencing.
module tb_debayer_line_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debayer_line_sched_if bus ();

  debayer_line_sched dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Monitor state, sampled on the falling edge.
  int         wr_cnt = 0, rd_cnt = 0, rgb_cnt = 0;
  int         nreads = 0, nlines = 0;
  int         addr_err = 0, lag_err = 0, max_addr = 0;
  logic [1:0] skip_log [64];
  logic [1:0] wsel_log [64];
  logic       prev_rd_en = 1'b0, prev_wr_en = 1'b0, prev_odd = 1'b0;
  int         prev_addr = 0;
  logic [1:0] rd_hist = 2'b00;

  always @(negedge clk) begin
    rd_hist    <= {rd_hist[0], bus.rd_en};
    prev_rd_en <= bus.rd_en;
    prev_wr_en <= bus.wr_en;
    prev_odd   <= bus.rd_odd;
    prev_addr  <= int'(bus.rd_addr);
    if (!rst) begin
      if (bus.wr_en)     wr_cnt  <= wr_cnt + 1;
      if (bus.rd_en)     rd_cnt  <= rd_cnt + 1;
      if (bus.rgb_valid) rgb_cnt <= rgb_cnt + 1;
      if (bus.rgb_valid !== rd_hist[1]) lag_err <= lag_err + 1;
      if (bus.rd_en && !prev_rd_en) begin
        skip_log[nreads % 64] <= bus.rd_skip_sel;
        nreads                <= nreads + 1;
        if (bus.rd_addr !== '0 || bus.rd_odd !== 1'b0) addr_err <= addr_err + 1;
      end
      if (bus.rd_en && prev_rd_en) begin
        if (bus.rd_odd !== ~prev_odd ||
            int'(bus.rd_addr) != (prev_odd ? prev_addr + 1 : prev_addr)) begin
          addr_err <= addr_err + 1;
        end
      end
      if (bus.rd_en && int'(bus.rd_addr) > max_addr) max_addr <= int'(bus.rd_addr);
      if (bus.wr_en && !prev_wr_en) begin
        wsel_log[nlines % 64] <= bus.wr_sel;
        nlines                <= nlines + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
  endtask

  task automatic send_line(input int words, input int gap);
    bus.data_valid = 1'b1;
    tick(words);
    bus.data_valid = 1'b0;
    tick(gap);
  endtask

  int         w0, r0, g0, d0, l0, r1, lo;
  logic [1:0] sel0;
  logic [1:0] exp_skip1 [3] = '{2'd3, 2'd0, 2'd1};
  logic [1:0] exp_skip3 [3] = '{2'd3, 2'd0, 2'd2};

  initial begin
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.data_valid  = 1'b0;
    bus.err_clr     = 1'b0;
    tick(3);

    // Reset state
    check("rst_wr_en", 32'(bus.wr_en), 0);
    check("rst_wr_sel", 32'(bus.wr_sel), 0);
    check("rst_wr_addr", 32'(bus.wr_addr), 0);
    check("rst_rd_en", 32'(bus.rd_en), 0);
    check("rst_rd_addr", 32'(bus.rd_addr), 0);
    check("rst_rd_odd", 32'(bus.rd_odd), 0);
    check("rst_skip", 32'(bus.rd_skip_sel), 3);
    check("rst_rgb", 32'(bus.rgb_valid), 0);
    check("rst_lines_out", 32'(bus.lines_out), 0);
    check("rst_errs", {30'd0, bus.err_len, bus.err_overrun}, 0);
    rst = 1'b0;
    tick(2);

    // Normal frame: 5 lines of 640 words, 1400-cycle gaps
    pulse_fs();
    w0 = wr_cnt; g0 = rgb_cnt; r0 = nreads; l0 = nlines; d0 = rd_cnt;
    bus.data_valid = 1'b1;
    tick(1);
    check("first_wr_en", 32'(bus.wr_en), 1);
    check("first_wr_addr", 32'(bus.wr_addr), 0);
    tick(9);
    check("wr_addr_9", 32'(bus.wr_addr), 9);
    tick(630);
    check("last_wr_en", 32'(bus.wr_en), 1);
    check("last_wr_addr", 32'(bus.wr_addr), 639);
    bus.data_valid = 1'b0;
    tick(1);
    check("wr_en_after_line", 32'(bus.wr_en), 0);
    tick(1399);
    send_line(640, 1400);
    bus.data_valid = 1'b1;
    tick(640);
    bus.data_valid = 1'b0;
    tick(1);
    check("rd_en_c+1", 32'(bus.rd_en), 0);
    tick(1);
    check("rd_en_c+2", 32'(bus.rd_en), 1);
    check("rd_skip_first", 32'(bus.rd_skip_sel), 3);
    check("rd_addr_first", 32'(bus.rd_addr), 0);
    tick(1398);
    send_line(640, 1400);
    send_line(640, 1400);
    check("n_lines", 32'(nlines - l0), 5);
    for (int i = 0; i < 5; i++) check($sformatf("wr_sel_seq%0d", i), 32'(wsel_log[l0 + i]), i % 4);
    check("n_reads", 32'(nreads - r0), 3);
    for (int i = 0; i < 3; i++) check($sformatf("skip_seq%0d", i), 32'(skip_log[r0 + i]), 32'(exp_skip1[i]));
    check("lines_out_3", 32'(bus.lines_out), 3);
    check("wr_pulses", 32'(wr_cnt - w0), 3200);
    check("rd_cycles", 32'(rd_cnt - d0), 3840);
    check("rgb_cycles", 32'(rgb_cnt - g0), 3840);
    check("rd_addr_seq", 32'(addr_err), 0);
    check("rd_addr_max", 32'(max_addr), 639);
    check("rgb_lag", 32'(lag_err), 0);
    check("no_err_len", 32'(bus.err_len), 0);
    check("no_err_ovr", 32'(bus.err_overrun), 0);

    // Overlong line: 645 words
    pulse_fs();
    w0 = wr_cnt;
    send_line(645, 2);
    check("long_wr_pulses", 32'(wr_cnt - w0), 640);
    check("long_err_len", 32'(bus.err_len), 1);
    check("long_wr_addr", 32'(bus.wr_addr), 640);
    check("long_wr_sel", 32'(bus.wr_sel), 1);
    tick(20);
    check("err_len_sticky", 32'(bus.err_len), 1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("err_len_clr", 32'(bus.err_len), 0);

    // 800-cycle line period: overrun at 5th line start, pending keeps newest triple
    pulse_fs();
    r0 = nreads; g0 = rgb_cnt;
    repeat (4) send_line(640, 160);
    check("ovr_before_5", 32'(bus.err_overrun), 0);
    bus.data_valid = 1'b1;
    tick(1);
    check("ovr_at_5", 32'(bus.err_overrun), 1);
    tick(639);
    bus.data_valid = 1'b0;
    tick(160);
    send_line(640, 2500);
    check("ovr_n_reads", 32'(nreads - r0), 3);
    for (int i = 0; i < 3; i++) check($sformatf("ovr_skip%0d", i), 32'(skip_log[r0 + i]), 32'(exp_skip3[i]));
    check("ovr_lines_out", 32'(bus.lines_out), 3);
    check("ovr_rgb_cycles", 32'(rgb_cnt - g0), 3840);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("ovr_clr", 32'(bus.err_overrun), 0);

    // Frame abort at pixel 300 of a read
    pulse_fs();
    r0 = nreads;
    repeat (2) send_line(640, 200);
    bus.data_valid = 1'b1;
    tick(640);
    bus.data_valid = 1'b0;
    tick(2);
    check("abort_rd_running", 32'(bus.rd_en), 1);
    tick(300);
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
    check("abort_rd_en", 32'(bus.rd_en), 0);
    check("abort_lines_out", 32'(bus.lines_out), 0);
    check("abort_wr_sel", 32'(bus.wr_sel), 0);
    check("abort_rgb_drain", 32'(bus.rgb_valid), 1);
    tick(2);
    check("abort_rgb_done", 32'(bus.rgb_valid), 0);
    r1 = nreads;
    check("abort_one_read", 32'(r1 - r0), 1);
    repeat (2) send_line(640, 200);
    tick(1500);
    check("abort_no_read_2", 32'(nreads), 32'(r1));
    send_line(640, 200);
    tick(1500);
    check("abort_read_3", 32'(nreads), 32'(r1 + 1));
    check("abort_lines_out_1", 32'(bus.lines_out), 1);

    // data_valid between frame_end and frame_start is ignored
    bus.frame_end = 1'b1;
    tick(1);
    bus.frame_end = 1'b0;
    w0 = wr_cnt; sel0 = bus.wr_sel; lo = int'(bus.lines_out); r0 = nreads;
    repeat (3) send_line(10, 5);
    tick(20);
    check("idle_wr_pulses", 32'(wr_cnt - w0), 0);
    check("idle_wr_sel", 32'(bus.wr_sel), 32'(sel0));
    check("idle_lines_out", 32'(bus.lines_out), 32'(lo));
    check("idle_reads", 32'(nreads), 32'(r0));
    check("idle_errs", {30'd0, bus.err_len, bus.err_overrun}, 0);
    pulse_fs();
    check("new_frame_lines_out", 32'(bus.lines_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
